// File: rtl/pc_unit_if.sv
// Fetch-stage control bundle between the decode/CP0 side and the PC unit.
interface pc_unit_if;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [2:0]  npc_op;
    logic [31:0] cmp_o;
    logic [31:0] pc_D;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic [31:0] pc_F;
    logic        bd_F;
    logic        adel_F;
    logic [31:0] pc8_D;

    modport master (
        output stall, req, eret, epc, npc_op, cmp_o, pc_D, imm16, instr_index, rs_data,
        input  pc_F, bd_F, adel_F, pc8_D
    );

    modport slave (
        input  stall, req, eret, epc, npc_op, cmp_o, pc_D, imm16, instr_index, rs_data,
        output pc_F, bd_F, adel_F, pc8_D
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC register with branch/jump/exception redirect, delay-slot flag,
// fetch address-error detection and link-address generation.
module pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);
    localparam int unsigned PC_W  = 32;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_PC4    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(1);
    localparam logic [OP_W-1:0] OP_J      = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JR     = OP_W'(3);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;
    logic            is_ctrl;

    assign pc_plus4      = pc_q + PC_W'(4);
    // Branch offset is word-scaled and relative to the delay slot (pc_D + 4).
    assign branch_target = bus.pc_D + PC_W'(4)
                         + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign jump_target   = {bus.pc_D[31:28], bus.instr_index, 2'b00};

    assign is_ctrl = (bus.npc_op == OP_BRANCH) || (bus.npc_op == OP_J)
                  || (bus.npc_op == OP_JR);

    // Next fetch address; reserved op codes fall through to sequential fetch.
    always_comb begin
        pc_next = pc_plus4;
        if (bus.req) begin
            pc_next = HANDLER_PC;
        end else if (bus.eret) begin
            pc_next = bus.epc;
        end else if (bus.stall) begin
            pc_next = pc_q;
        end else begin
            case (bus.npc_op)
                OP_PC4:    pc_next = pc_plus4;
                OP_BRANCH: pc_next = bus.cmp_o[0] ? branch_target : pc_plus4;
                OP_J:      pc_next = jump_target;
                OP_JR:     pc_next = bus.rs_data;
                default:   pc_next = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign bus.pc_F   = pc_q;
    assign bus.bd_F   = is_ctrl && !bus.req && !bus.eret;
    assign bus.adel_F = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
    assign bus.pc8_D  = bus.pc_D + PC_W'(8);
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_unit_if bus ();

    pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.req = 1'b0;
        bus.eret = 1'b0;
        bus.epc = 32'h0;
        bus.npc_op = 3'd0;
        bus.cmp_o = 32'h0;
        bus.pc_D = 32'h0000_3000;
        bus.imm16 = 16'h0;
        bus.instr_index = 26'h0;
        bus.rs_data = 32'h0;

        // Reset and sequential fetch
        step();
        check("reset_pc", bus.pc_F, 32'h0000_3000);
        reset = 1'b0;
        #1;
        check("reset_bd", {31'b0, bus.bd_F}, 32'd0);
        check("reset_adel", {31'b0, bus.adel_F}, 32'd0);
        check("reset_pc8", bus.pc8_D, 32'h0000_3008);
        step();
        check("seq1", bus.pc_F, 32'h0000_3004);
        step();
        check("seq2", bus.pc_F, 32'h0000_3008);
        step();
        check("seq3", bus.pc_F, 32'h0000_300C);

        // Backward branch taken, then not taken with only cmp_o[1] set
        bus.pc_D = 32'h0000_3010;
        bus.npc_op = 3'd1;
        bus.imm16 = 16'hFFFC;
        bus.cmp_o = 32'h1;
        #1;
        check("br_bd", {31'b0, bus.bd_F}, 32'd1);
        check("br_pc8", bus.pc8_D, 32'h0000_3018);
        step();
        check("br_taken", bus.pc_F, 32'h0000_3004);
        bus.cmp_o = 32'h2;
        #1;
        check("br_nt_bd", {31'b0, bus.bd_F}, 32'd1);
        step();
        check("br_not_taken", bus.pc_F, 32'h0000_3008);

        // J and misaligned JR
        bus.npc_op = 3'd2;
        bus.pc_D = 32'h0000_3020;
        bus.instr_index = 26'h0000C10;
        step();
        check("j_target", bus.pc_F, 32'h0000_3040);
        check("j_adel", {31'b0, bus.adel_F}, 32'd0);
        bus.npc_op = 3'd3;
        bus.rs_data = 32'h0000_3001;
        step();
        check("jr_target", bus.pc_F, 32'h0000_3001);
        check("jr_adel", {31'b0, bus.adel_F}, 32'd1);

        // Stalled branch is re-evaluated each cycle
        bus.npc_op = 3'd1;
        bus.pc_D = 32'h0000_3010;
        bus.imm16 = 16'hFFFC;
        bus.cmp_o = 32'h0;
        bus.stall = 1'b1;
        step();
        check("stall1", bus.pc_F, 32'h0000_3001);
        bus.cmp_o = 32'h1;
        step();
        check("stall2", bus.pc_F, 32'h0000_3001);
        bus.stall = 1'b0;
        step();
        check("stall_release", bus.pc_F, 32'h0000_3004);

        // Exception request beats eret and stall; then eret returns to epc
        bus.req = 1'b1;
        bus.stall = 1'b1;
        bus.eret = 1'b1;
        bus.epc = 32'h0000_3058;
        #1;
        check("req_bd", {31'b0, bus.bd_F}, 32'd0);
        step();
        check("req_handler", bus.pc_F, 32'h0000_4180);
        bus.req = 1'b0;
        bus.stall = 1'b0;
        #1;
        check("eret_bd", {31'b0, bus.bd_F}, 32'd0);
        step();
        check("eret_epc", bus.pc_F, 32'h0000_3058);
        bus.eret = 1'b0;

        // Reset overrides req and a pending taken branch
        bus.req = 1'b1;
        bus.cmp_o = 32'h1;
        reset = 1'b1;
        step();
        check("reset_over_req", bus.pc_F, 32'h0000_3000);
        reset = 1'b0;
        bus.req = 1'b0;

        // Upper boundary of instruction memory
        bus.npc_op = 3'd3;
        bus.rs_data = 32'h0000_6FFC;
        step();
        check("hi_edge", bus.pc_F, 32'h0000_6FFC);
        check("hi_edge_adel", {31'b0, bus.adel_F}, 32'd0);
        bus.npc_op = 3'd0;
        #1;
        check("pc4_bd", {31'b0, bus.bd_F}, 32'd0);
        step();
        check("hi_over", bus.pc_F, 32'h0000_7000);
        check("hi_over_adel", {31'b0, bus.adel_F}, 32'd1);

        // Reserved op behaves as PC4
        bus.npc_op = 3'd5;
        #1;
        check("rsv_bd", {31'b0, bus.bd_F}, 32'd0);
        step();
        check("rsv_pc4", bus.pc_F, 32'h0000_7004);

        // Address wrap and below-range error
        bus.npc_op = 3'd3;
        bus.rs_data = 32'hFFFF_FFFC;
        step();
        check("wrap_src", bus.pc_F, 32'hFFFF_FFFC);
        bus.npc_op = 3'd0;
        step();
        check("wrap", bus.pc_F, 32'h0000_0000);
        check("lo_adel", {31'b0, bus.adel_F}, 32'd1);
        bus.pc_D = 32'hFFFF_FFFC;
        #1;
        check("pc8_wrap", bus.pc8_D, 32'h0000_0004);

        // Forward branch with positive offset
        bus.pc_D = 32'h0000_3100;
        bus.npc_op = 3'd1;
        bus.imm16 = 16'h0010;
        bus.cmp_o = 32'hFFFF_FFFF;
        step();
        check("br_fwd", bus.pc_F, 32'h0000_3144);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
